video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 The block SHALL have parameters H_FP 110, H_SYNC 40, H_BP 220: horizontal front porch, sync and back porch in pixels (H_TOTAL = 1650).
REQ-003 The block SHALL have parameters V_ACTIVE 720, V_FP 5, V_SYNC 5, V_BP 20: vertical active, front porch, sync and back porch in lines (V_TOTAL = 750).
REQ-004 The block SHALL have parameters HSYNC_POL 1 and VSYNC_POL 1: the asserted level of each sync output.
REQ-005 The block SHALL have port clk, input, 1 bit: pixel clock, the only clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port ce, input, 1 bit: pixel advance enable.
REQ-008 The block SHALL have port hcount, output, 12 bits: current pixel column, 0..H_TOTAL-1.
REQ-009 The block SHALL have port vcount, output, 12 bits: current line, 0..V_TOTAL-1.
REQ-010 The block SHALL have port de, output, 1 bit: data enable, high inside the active area.
REQ-011 The block SHALL have ports hsync and vsync, outputs, 1 bit each: sync pulses at the configured polarity.
REQ-012 The block SHALL have port frame_start, output, 1 bit: one-pixel pulse at (0,0).
REQ-013 The block SHALL have port line_start, output, 1 bit: one-pixel pulse whenever hcount is 0.

Function
REQ-014 All outputs SHALL be registered and mutually aligned, so that de, hsync, vsync, frame_start and line_start describe the same pixel as the concurrent hcount and vcount.
REQ-015 The horizontal axis SHALL step through states H_ACT (0..1279), H_FP (1280..1389), H_SYNC (1390..1429) and H_BP (1430..1649), then return to H_ACT.
REQ-016 On each clk edge with ce=1, hcount SHALL increment, and SHALL wrap H_TOTAL-1 to 0.
REQ-017 vcount SHALL increment only when hcount wraps, and SHALL wrap V_TOTAL-1 to 0 on the same edge that hcount wraps.
REQ-018 The block SHALL drive de=1 exactly when hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-019 The block SHALL drive hsync=HSYNC_POL exactly when hcount is in [1390,1429].
REQ-020 The block SHALL drive vsync=VSYNC_POL exactly when vcount is in [725,729], for whole lines, independent of hcount.
REQ-021 When ce=0, all outputs SHALL hold their values, including frame_start and line_start, which stay asserted if they were asserted.
REQ-022 Counters SHALL never exceed their TOTAL-1 values, and all arithmetic SHALL be 12-bit unsigned.

Reset
REQ-023 While rst=1, the block SHALL load hcount=H_TOTAL-1 and vcount=V_TOTAL-1, and drive de=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL, frame_start=0 and line_start=0.
REQ-024 rst SHALL take priority over ce.
REQ-025 An assertion of rst mid-frame SHALL abandon the current frame immediately.
REQ-026 On the first ce=1 edge after rst deasserts, the block SHALL produce (0,0) with de=1, frame_start=1 and line_start=1.

Configuration
REQ-027 With macro VIDEO_TIMING_FRAME_CNT_EN defined, the block SHALL add output frame_count (16 bits), which is reset to 0, increments together with the frame_start assertion, and wraps 0xFFFF to 0.
REQ-028 Without VIDEO_TIMING_FRAME_CNT_EN, the frame_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package video_timing_pkg SHALL hold the 720p60 timing constants, the derived H_TOTAL and V_TOTAL, the 12-bit coordinate typedef and the horizontal-state enum.
REQ-030 Sub-module video_timing_axis (a wrapping counter with region decode) SHALL be instantiated twice: horizontal, advanced by ce, and vertical, advanced by the horizontal wrap.

Verification
REQ-031 Reset then ce=1 continuously -> the first output is (0,0) with de=1 and frame_start=1; one cycle later the output is (1,0) with frame_start=0.
REQ-032 Full line -> de is high for exactly 1280 cycles, and hsync is high for 40 cycles starting at hcount=1390; the line period is 1650 cycles.
REQ-033 Full frame -> frame_start pulses every 1,237,500 cycles, vsync covers lines 725..729 (8250 cycles), and de totals 921,600 cycles.
REQ-034 Wrap corner (1649,749) -> the next output is (0,0) with frame_start=1, and frame_count increments from N to N+1 when the macro is defined.
REQ-035 ce toggling 1,0,0,1 -> all outputs freeze during the ce=0 cycles and advance exactly one pixel per ce=1 cycle.
REQ-036 rst pulsed for one cycle at (640,360) with ce=1 -> the output is (1649,749) with de=0 during reset, and (0,0) with frame_start=1 on the next edge.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared definitions for the video timing generator: 720p60 timing
//   constants (horizontal and vertical), derived totals, the 12-bit
//   coordinate type, the axis region enum and a region decode helper.
package video_timing_pkg;

  localparam int unsigned VT_H_ACTIVE = 1280;
  localparam int unsigned VT_H_FP     = 110;
  localparam int unsigned VT_H_SYNC   = 40;
  localparam int unsigned VT_H_BP     = 220;
  localparam int unsigned VT_H_TOTAL  = VT_H_ACTIVE + VT_H_FP + VT_H_SYNC + VT_H_BP;

  localparam int unsigned VT_V_ACTIVE = 720;
  localparam int unsigned VT_V_FP     = 5;
  localparam int unsigned VT_V_SYNC   = 5;
  localparam int unsigned VT_V_BP     = 20;
  localparam int unsigned VT_V_TOTAL  = VT_V_ACTIVE + VT_V_FP + VT_V_SYNC + VT_V_BP;

  localparam int unsigned COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;

  // Region of a timing axis; named after the horizontal line but reused
  // for the vertical axis, which has the same four phases.
  typedef enum logic [1:0] {
    ST_ACT  = 2'd0,
    ST_FP   = 2'd1,
    ST_SYNC = 2'd2,
    ST_BP   = 2'd3
  } h_state_e;

  // Boundaries are exclusive end positions of each region.
  function automatic h_state_e region_of(input coord_t c,
                                         input coord_t act_end,
                                         input coord_t fp_end,
                                         input coord_t sync_end);
    h_state_e r;
    if (c < act_end)       r = ST_ACT;
    else if (c < fp_end)   r = ST_FP;
    else if (c < sync_end) r = ST_SYNC;
    else                   r = ST_BP;
    return r;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// video_timing_axis
//   One timing axis: a wrapping counter 0..TOTAL-1 plus region decode of
//   the value it is about to take.
//   Ports:
//     clk          pixel clock
//     rst          synchronous active-high reset, loads TOTAL-1
//     adv_i        advance the counter by one on this edge
//     count_o      current (registered) count
//     count_nxt_o  value the counter takes on the next edge
//     region_nxt_o region of count_nxt_o
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = VT_H_ACTIVE,
  parameter int unsigned FP     = VT_H_FP,
  parameter int unsigned SYNC   = VT_H_SYNC,
  parameter int unsigned BP     = VT_H_BP
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     adv_i,
  output coord_t   count_o,
  output coord_t   count_nxt_o,
  output h_state_e region_nxt_o
);

  localparam coord_t LAST     = coord_t'(ACTIVE + FP + SYNC + BP - 1);
  localparam coord_t ACT_END  = coord_t'(ACTIVE);
  localparam coord_t FP_END   = coord_t'(ACTIVE + FP);
  localparam coord_t SYNC_END = coord_t'(ACTIVE + FP + SYNC);

  coord_t count_q;
  coord_t count_d;

  always_comb begin
    count_d = count_q;
    if (adv_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + coord_t'(1);
    end
    region_nxt_o = region_of(count_d, ACT_END, FP_END, SYNC_END);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= LAST;
    else     count_q <= count_d;
  end

  assign count_o     = count_q;
  assign count_nxt_o = count_d;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator (default 1280x720p60). All outputs are
//   registered and describe the same pixel as hcount/vcount.
//   Ports:
//     clk          pixel clock
//     rst          synchronous active-high reset (priority over ce)
//     ce           pixel advance enable; outputs hold when low
//     hcount       current column 0..H_TOTAL-1
//     vcount       current line 0..V_TOTAL-1
//     de           high inside the active area
//     hsync/vsync  sync pulses at HSYNC_POL/VSYNC_POL
//     frame_start  high at pixel (0,0)
//     line_start   high whenever hcount is 0
//     frame_count  16-bit frame counter (only with VIDEO_TIMING_FRAME_CNT_EN)
//   Build option: define VIDEO_TIMING_FRAME_CNT_EN to add frame_count.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VT_H_ACTIVE,
  parameter int unsigned H_FP      = VT_H_FP,
  parameter int unsigned H_SYNC    = VT_H_SYNC,
  parameter int unsigned H_BP      = VT_H_BP,
  parameter int unsigned V_ACTIVE  = VT_V_ACTIVE,
  parameter int unsigned V_FP      = VT_V_FP,
  parameter int unsigned V_SYNC    = VT_V_SYNC,
  parameter int unsigned V_BP      = VT_V_BP,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        line_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam coord_t H_LAST = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  coord_t   h_count, h_count_nxt;
  coord_t   v_count, v_count_nxt;
  h_state_e h_region_nxt, v_region_nxt;
  logic     v_adv;

  // Vertical steps on the same edge the horizontal counter wraps.
  assign v_adv = ce && (h_count == H_LAST);

  video_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk          (clk),
    .rst          (rst),
    .adv_i        (ce),
    .count_o      (h_count),
    .count_nxt_o  (h_count_nxt),
    .region_nxt_o (h_region_nxt)
  );

  video_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk          (clk),
    .rst          (rst),
    .adv_i        (v_adv),
    .count_o      (v_count),
    .count_nxt_o  (v_count_nxt),
    .region_nxt_o (v_region_nxt)
  );

  logic de_q, hsync_q, vsync_q, fs_q, ls_q;
  logic de_d, hsync_d, vsync_d, fs_d, ls_d;

  // Flags are decoded from the counters' next values and registered with
  // the same enable, so they line up with the registered counts.
  always_comb begin
    de_d    = (h_region_nxt == ST_ACT) && (v_region_nxt == ST_ACT);
    hsync_d = (h_region_nxt == ST_SYNC) ? HSYNC_POL : !HSYNC_POL;
    vsync_d = (v_region_nxt == ST_SYNC) ? VSYNC_POL : !VSYNC_POL;
    ls_d    = (h_count_nxt == '0);
    fs_d    = (h_count_nxt == '0) && (v_count_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q    <= 1'b0;
      hsync_q <= !HSYNC_POL;
      vsync_q <= !VSYNC_POL;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else if (ce) begin
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign hcount      = h_count;
  assign vcount      = v_count;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)               frame_cnt_q <= '0;
    else if (ce && fs_d)   frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_count = frame_cnt_q;
`endif

endmodule
